riscv_fetch_unit: RTL

RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/riscv_fetch_unit.sv | 86 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: default reset vector and the buffered entry layout.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous circular FIFO with flush taking priority over push/pop.
// The head reads as all zeros while the buffer is empty.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  entry_t        mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !flush;
  assign do_pop   = pop && !flush && !empty;
  assign empty    = (count == '0);
  assign full     = (count == (AW + 1)'(DEPTH));
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The fetch unit's credit scheme must never push into a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch: issues word reads ahead of decode, tracks one read in flight,
// and buffers returned instructions with their PCs. A redirect flushes everything.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH          = 32,
  parameter int                    INST_MEM_ADDR_WIDTH = 12,
  parameter int                    FIFO_DEPTH          = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC            = RESET_PC_DEFAULT
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  output logic [INST_MEM_ADDR_WIDTH-3:0] o_addr_inst,
  output logic                           o_req_inst,
  input  logic [DATA_WIDTH-1:0]          i_rdata_inst,
  input  logic                           i_redirect,
  input  logic [DATA_WIDTH-1:0]          i_redirect_pc,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [DATA_WIDTH-1:0]          o_inst,
  output logic [DATA_WIDTH-1:0]          o_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } entry_t;

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] inflight_pc;
  logic                  inflight_valid;
  entry_t                push_entry;
  entry_t                head;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [CW:0]           occupancy;

  // Credit counts buffered plus in-flight entries only; a same-cycle pop frees a slot next cycle.
  assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_valid};
  assign o_req_inst  = i_rst_n && !i_redirect && !fifo_full &&
                       (occupancy < (CW + 1)'(FIFO_DEPTH));
  assign o_addr_inst = pc[INST_MEM_ADDR_WIDTH-1:2];

  assign o_valid    = !fifo_empty && !i_redirect;
  assign pop        = o_valid && i_ready;
  assign push       = inflight_valid && !i_redirect;
  assign push_entry = {inflight_pc, i_rdata_inst};
  assign o_inst     = head.inst;
  assign o_pc       = head.pc;

  // Fetch PC and the single in-flight read slot; a redirect kills the slot and retargets.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc             <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
    end else begin
      if (i_redirect)      pc <= i_redirect_pc & ~DATA_WIDTH'(3);
      else if (o_req_inst) pc <= pc + DATA_WIDTH'(4);
      inflight_valid <= o_req_inst;
      if (o_req_inst) inflight_pc <= pc;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .flush     (i_redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
